packet_framer: RTL and testbench

- Upstream feeder for the sequence parser.
- Accepts a per-packet descriptor (stream id, total length) and a byte-wide payload stream, and emits the 32-bit framed word stream the parser consumes.
- Word stream format: header word {length LE, stream LE}, then sequence word (LE), then payload packed 4 bytes per word, with a last flag on the final word.
- Keeps one 32-bit sequence counter per stream; the parser checks it to flag lost packets.

---
 rtl/packet_framer.sv | 153 +++++++++++++++
 tb/tb_packet_framer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_framer.sv
// rtl/packet_framer.sv - descriptor + byte stream to framed 32-bit word stream
// Optional per-packet retire counter output pktCount under FRAMER_PKT_CNT_EN.
module packet_framer #(
  parameter int          NUM_STREAMS = 16,
  parameter int          MAX_LEN     = 1024,
  parameter logic [31:0] SEQ_INIT    = 32'd1
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic [15:0] desc_stream,
  input  logic [15:0] desc_len,
  input  logic        desc_val,
  output logic        desc_ready,
  input  logic [7:0]  byteIn,
  input  logic        byteIn_val,
  output logic        byteIn_ready,
  output logic [31:0] dataOut,
  output logic        dataOut_val,
  input  logic        dataOut_ready,
  output logic        dataOut_last,
  output logic        descError
`ifdef FRAMER_PKT_CNT_EN
  ,
  output logic [31:0] pktCount
`endif
);

  localparam int          IDXW          = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;
  localparam logic [15:0] MAX_LEN_W     = 16'(MAX_LEN);
  localparam logic [16:0] NUM_STREAMS_W = 17'(NUM_STREAMS);

  typedef enum logic [1:0] {IDLE, HDR0, HDR1, PAYLOAD} state_t;

  state_t      state, stateNext;
  logic [31:0] seqTable [NUM_STREAMS];
  logic [15:0] curStream, curLen, bytesLeft, leftAfter;
  logic [31:0] curSeq, acc, accWithByte, outData;
  logic [2:0]  accCnt, cntWithByte;
  logic        outVal, outLast, descRdyQ, descErrQ;
  logic        descBad, descTake, isShort, byteTake, wordReady, outFree, moveWord, retire;

  assign descBad  = (desc_len < 16'd8) || (desc_len > MAX_LEN_W) ||
                    ({1'b0, desc_stream} >= NUM_STREAMS_W);
  assign descTake = desc_val && descRdyQ;
  assign isShort  = (curLen <= 16'd8);

  assign byteIn_ready = (state == PAYLOAD) && (accCnt != 3'd4) && (bytesLeft != 16'd0);
  assign byteTake     = byteIn_val && byteIn_ready;

  // Bytes are placed from the top lane down; a cleared accumulator gives zero padding.
  assign accWithByte = byteTake ? (acc | ({byteIn, 24'd0} >> {accCnt[1:0], 3'b000})) : acc;
  assign cntWithByte = accCnt + {2'b00, byteTake};
  assign leftAfter   = bytesLeft - {15'd0, byteTake};
  assign wordReady   = (cntWithByte == 3'd4) || ((cntWithByte != 3'd0) && (leftAfter == 16'd0));
  assign outFree     = !outVal || dataOut_ready;
  assign moveWord    = (state == PAYLOAD) && wordReady && outFree;
  assign retire      = outVal && dataOut_ready &&
                       (((state == HDR1) && isShort) || ((state == PAYLOAD) && outLast));

  assign desc_ready   = descRdyQ;
  assign descError    = descErrQ;
  assign dataOut      = outData;
  assign dataOut_val  = outVal;
  assign dataOut_last = outLast;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) state <= IDLE;
    else          state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (descTake && !descBad) stateNext = HDR0;
      HDR0:    if (dataOut_ready) stateNext = HDR1;
      HDR1:    if (dataOut_ready) stateNext = isShort ? IDLE : PAYLOAD;
      PAYLOAD: if (retire) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      for (int i = 0; i < NUM_STREAMS; i++) seqTable[i] <= SEQ_INIT;
      curStream <= '0;
      curLen    <= '0;
      curSeq    <= '0;
      bytesLeft <= '0;
      acc       <= '0;
      accCnt    <= '0;
      outData   <= '0;
      outVal    <= 1'b0;
      outLast   <= 1'b0;
      descRdyQ  <= 1'b0;
      descErrQ  <= 1'b0;
`ifdef FRAMER_PKT_CNT_EN
      pktCount  <= '0;
`endif
    end else begin
      descRdyQ <= (stateNext == IDLE);
      descErrQ <= descTake && descBad;
      case (state)
        IDLE: if (descTake && !descBad) begin
          curStream <= desc_stream;
          curLen    <= desc_len;
          curSeq    <= seqTable[desc_stream[IDXW-1:0]];
          bytesLeft <= desc_len - 16'd8;
          outData   <= {desc_len[7:0], desc_len[15:8], desc_stream[7:0], desc_stream[15:8]};
          outVal    <= 1'b1;
          outLast   <= 1'b0;
          acc       <= '0;
          accCnt    <= '0;
        end
        HDR0: if (dataOut_ready) begin
          outData <= {curSeq[7:0], curSeq[15:8], curSeq[23:16], curSeq[31:24]};
          outLast <= isShort;
        end
        HDR1: if (dataOut_ready) begin
          outData <= '0;
          outVal  <= 1'b0;
          outLast <= 1'b0;
        end
        PAYLOAD: begin
          if (moveWord) begin
            outData <= accWithByte;
            outVal  <= 1'b1;
            outLast <= (leftAfter == 16'd0);
            acc     <= '0;
            accCnt  <= '0;
          end else begin
            if (byteTake) begin
              acc    <= accWithByte;
              accCnt <= cntWithByte;
            end
            if (outVal && dataOut_ready) begin
              outVal  <= 1'b0;
              outLast <= 1'b0;
            end
          end
          if (byteTake) bytesLeft <= leftAfter;
        end
        default: ;
      endcase
      if (retire) begin
        seqTable[curStream[IDXW-1:0]] <= curSeq + 32'd1;
`ifdef FRAMER_PKT_CNT_EN
        pktCount <= pktCount + 32'd1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_packet_framer.sv
// tb/tb_packet_framer.sv - directed self-checking bench for packet_framer
// Checks pktCount as well when FRAMER_PKT_CNT_EN is defined.
module tb_packet_framer;

  logic        clk = 1'b0;
  logic        reset_b;
  logic [15:0] desc_stream, desc_len;
  logic        desc_val, desc_ready;
  logic [7:0]  byteIn;
  logic        byteIn_val, byteIn_ready;
  logic [31:0] dataOut;
  logic        dataOut_val, dataOut_ready, dataOut_last, descError;
`ifdef FRAMER_PKT_CNT_EN
  logic [31:0] pktCount;
`endif

  int vectors = 0;
  int miscompares = 0;
  int expPkt = 0;

  logic [31:0] capW [$];
  logic        capL [$];
  int          latency, accepted;
  bit          sawByteRdy, holdBad, sawRdyDrop, timedOut;

  always #5 clk = ~clk;

  packet_framer dut (
    .clk           (clk),
    .reset_b       (reset_b),
    .desc_stream   (desc_stream),
    .desc_len      (desc_len),
    .desc_val      (desc_val),
    .desc_ready    (desc_ready),
    .byteIn        (byteIn),
    .byteIn_val    (byteIn_val),
    .byteIn_ready  (byteIn_ready),
    .dataOut       (dataOut),
    .dataOut_val   (dataOut_val),
    .dataOut_ready (dataOut_ready),
    .dataOut_last  (dataOut_last),
    .descError     (descError)
`ifdef FRAMER_PKT_CNT_EN
    ,
    .pktCount      (pktCount)
`endif
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] payWord(input logic [7:0] b0, input int i, input int nb);
    logic [31:0] w;
    w = '0;
    for (int j = 0; j < 4; j++)
      if (4 * i + j < nb) w[31 - 8 * j -: 8] = 8'(int'(b0) + 4 * i + j);
    return w;
  endfunction

  // Drives one descriptor and its payload (surplus bytes kept on offer), captures output words.
  task automatic drive_packet(input logic [15:0] s, input logic [15:0] l, input logic [7:0] b0,
                              input int stallAt);
    int  nb, idx, cyc, takeCyc, firstVal, stallLeft;
    bit  pend, done, stalled;
    logic [31:0] hw;
    logic        hl;
    nb = (l >= 16'd8) ? int'(l) - 8 : 0;
    idx = 0; cyc = 0; takeCyc = -100; firstVal = -1; stallLeft = 0;
    pend = 1; done = 0; stalled = 0; hw = '0; hl = 1'b0;
    capW.delete(); capL.delete();
    sawByteRdy = 0; holdBad = 0; sawRdyDrop = 0;
    desc_stream = s; desc_len = l;
    while (!done && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      if (dataOut_val && firstVal < 0) firstVal = cyc;
      if (pend) begin
        desc_val = 1'b1;
        if (desc_ready) begin pend = 0; takeCyc = cyc; end
      end else desc_val = 1'b0;
      byteIn = 8'(int'(b0) + idx);
      byteIn_val = 1'b1;
      if (byteIn_ready) sawByteRdy = 1;
      if (byteIn_ready) idx++;
      if (stallAt >= 0 && !stalled && capW.size() == stallAt && dataOut_val) begin
        stalled = 1; stallLeft = 10; hw = dataOut; hl = dataOut_last;
      end
      if (stallLeft > 0) begin
        dataOut_ready = 1'b0;
        if (dataOut !== hw || dataOut_last !== hl || dataOut_val !== 1'b1) holdBad = 1;
        if (!byteIn_ready) sawRdyDrop = 1;
        stallLeft--;
      end else dataOut_ready = 1'b1;
      if (dataOut_val && dataOut_ready) begin
        capW.push_back(dataOut);
        capL.push_back(dataOut_last);
        if (dataOut_last) done = 1;
      end
    end
    @(posedge clk); #1;
    desc_val = 1'b0; byteIn_val = 1'b0; dataOut_ready = 1'b1;
    timedOut = !done;
    latency = firstVal - takeCyc;
    accepted = idx;
  endtask

  task automatic test_reset();
    reset_b = 1'b0; desc_val = 1'b0; byteIn_val = 1'b0; byteIn = '0;
    dataOut_ready = 1'b1; desc_stream = '0; desc_len = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (dataOut_val !== 1'b0) begin miscompares++; $display("FAIL reset_val: got %b want 0", dataOut_val); end
    vectors++; if (dataOut !== 32'h0) begin miscompares++; $display("FAIL reset_data: got %h want 0", dataOut); end
    vectors++; if (dataOut_last !== 1'b0) begin miscompares++; $display("FAIL reset_last: got %b want 0", dataOut_last); end
    vectors++; if (desc_ready !== 1'b0) begin miscompares++; $display("FAIL reset_desc_ready: got %b want 0", desc_ready); end
    vectors++; if (byteIn_ready !== 1'b0) begin miscompares++; $display("FAIL reset_byte_ready: got %b want 0", byteIn_ready); end
    vectors++; if (descError !== 1'b0) begin miscompares++; $display("FAIL reset_desc_error: got %b want 0", descError); end
`ifdef FRAMER_PKT_CNT_EN
    vectors++; if (pktCount !== 32'h0) begin miscompares++; $display("FAIL reset_pkt_count: got %0d want 0", pktCount); end
`endif
    reset_b = 1'b1;
    @(posedge clk); #1;
    vectors++; if (desc_ready !== 1'b1) begin miscompares++; $display("FAIL idle_desc_ready: got %b want 1", desc_ready); end
    expPkt = 0;
  endtask

  task automatic test_basic();
    logic [31:0] e [5] = '{32'h1400_0C00, 32'h0100_0000, 32'h0102_0304, 32'h0506_0708, 32'h090A_0B0C};
    drive_packet(16'd12, 16'd20, 8'h01, -1);
    expPkt++;
    vectors++; if (timedOut) begin miscompares++; $display("FAIL basic_timeout: got timeout want last word"); end
    vectors++; if (latency != 1) begin miscompares++; $display("FAIL basic_hdr_latency: got %0d want 1", latency); end
    vectors++; if (capW.size() != 5) begin miscompares++; $display("FAIL basic_count: got %0d want 5", capW.size()); end
    vectors++; if (accepted != 12) begin miscompares++; $display("FAIL basic_bytes: got %0d want 12", accepted); end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (i >= capW.size() || capW[i] !== e[i] || capL[i] !== (i == 4)) begin
        miscompares++;
        $display("FAIL basic_word%0d: got %h/%b want %h/%b", i,
                 (i < capW.size()) ? capW[i] : 32'hx, (i < capW.size()) ? capL[i] : 1'bx, e[i], i == 4);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e [7] = '{32'h1900_0D00, 32'h0100_0000, 32'hA0A1_A2A3, 32'hA4A5_A6A7,
                           32'hA8A9_AAAB, 32'hACAD_AEAF, 32'hB000_0000};
    drive_packet(16'd13, 16'd25, 8'hA0, -1);
    expPkt++;
    vectors++; if (timedOut) begin miscompares++; $display("FAIL b2b_timeout: got timeout want last word"); end
    vectors++; if (capW.size() != 7) begin miscompares++; $display("FAIL b2b_count: got %0d want 7", capW.size()); end
    vectors++; if (accepted != 17) begin miscompares++; $display("FAIL b2b_bytes: got %0d want 17", accepted); end
    for (int i = 0; i < 7; i++) begin
      vectors++;
      if (i >= capW.size() || capW[i] !== e[i] || capL[i] !== (i == 6)) begin
        miscompares++;
        $display("FAIL b2b_word%0d: got %h/%b want %h/%b", i,
                 (i < capW.size()) ? capW[i] : 32'hx, (i < capW.size()) ? capL[i] : 1'bx, e[i], i == 6);
      end
    end
    drive_packet(16'd13, 16'd25, 8'hA0, -1);
    expPkt++;
    vectors++; if (latency != 1) begin miscompares++; $display("FAIL b2b_second_latency: got %0d want 1", latency); end
    vectors++;
    if (capW.size() < 2 || capW[1] !== 32'h0200_0000) begin
      miscompares++;
      $display("FAIL b2b_second_seq: got %h want 02000000", (capW.size() > 1) ? capW[1] : 32'hx);
    end
  endtask

  task automatic test_short();
    drive_packet(16'd14, 16'd8, 8'h00, -1);
    expPkt++;
    vectors++; if (capW.size() != 2) begin miscompares++; $display("FAIL short_count: got %0d want 2", capW.size()); end
    vectors++;
    if (capW.size() < 2 || capW[0] !== 32'h0800_0E00 || capW[1] !== 32'h0100_0000 ||
        capL[0] !== 1'b0 || capL[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL short_words: got %h/%h want 08000e00/01000000 last on second",
               (capW.size() > 0) ? capW[0] : 32'hx, (capW.size() > 1) ? capW[1] : 32'hx);
    end
    vectors++; if (sawByteRdy) begin miscompares++; $display("FAIL short_byte_ready: got 1 want never"); end
  endtask

  task automatic test_stall();
    drive_packet(16'd5, 16'd36, 8'h10, 3);
    expPkt++;
    vectors++; if (timedOut) begin miscompares++; $display("FAIL stall_timeout: got timeout want last word"); end
    vectors++; if (holdBad) begin miscompares++; $display("FAIL stall_hold: got changing output want stable"); end
    vectors++; if (!sawRdyDrop) begin miscompares++; $display("FAIL stall_ready_drop: got no drop want byteIn_ready 0"); end
    vectors++; if (accepted != 28) begin miscompares++; $display("FAIL stall_bytes: got %0d want 28", accepted); end
    vectors++; if (capW.size() != 9) begin miscompares++; $display("FAIL stall_count: got %0d want 9", capW.size()); end
    for (int i = 0; i < 9; i++) begin
      logic [31:0] ew;
      ew = (i == 0) ? 32'h2400_0500 : (i == 1) ? 32'h0100_0000 : payWord(8'h10, i - 2, 28);
      vectors++;
      if (i >= capW.size() || capW[i] !== ew || capL[i] !== (i == 8)) begin
        miscompares++;
        $display("FAIL stall_word%0d: got %h want %h", i, (i < capW.size()) ? capW[i] : 32'hx, ew);
      end
    end
  endtask

  task automatic test_reject();
    logic [15:0] bs [3] = '{16'd12, 16'd16, 16'd12};
    logic [15:0] bl [3] = '{16'd7, 16'd20, 16'd1025};
    int errs, vals;
    for (int i = 0; i < 3; i++) begin
      desc_stream = bs[i]; desc_len = bl[i]; errs = 0; vals = 0;
      @(posedge clk); #1;
      vectors++; if (desc_ready !== 1'b1) begin miscompares++; $display("FAIL reject%0d_ready: got %b want 1", i, desc_ready); end
      desc_val = 1'b1;
      @(posedge clk); #1;
      desc_val = 1'b0;
      repeat (6) begin
        if (descError) errs++;
        if (dataOut_val) vals++;
        @(posedge clk); #1;
      end
      vectors++; if (errs != 1) begin miscompares++; $display("FAIL reject%0d_pulse: got %0d want 1", i, errs); end
      vectors++; if (vals != 0) begin miscompares++; $display("FAIL reject%0d_words: got %0d want 0", i, vals); end
    end
`ifdef FRAMER_PKT_CNT_EN
    vectors++; if (pktCount !== 32'(expPkt)) begin miscompares++; $display("FAIL reject_pkt_count: got %0d want %0d", pktCount, expPkt); end
`endif
    drive_packet(16'd12, 16'd12, 8'h55, -1);
    expPkt++;
    vectors++;
    if (capW.size() != 3 || capW[0] !== 32'h0C00_0C00 || capW[1] !== 32'h0200_0000 ||
        capW[2] !== 32'h5556_5758 || capL[2] !== 1'b1) begin
      miscompares++;
      $display("FAIL reject_seq_kept: got %0d words seq %h want 3 words seq 02000000",
               capW.size(), (capW.size() > 1) ? capW[1] : 32'hx);
    end
  endtask

  task automatic test_reset_mid();
    desc_stream = 16'd12; desc_len = 16'd20; dataOut_ready = 1'b1;
    byteIn = 8'h01; byteIn_val = 1'b1;
    @(posedge clk); #1;
    desc_val = 1'b1;
    @(posedge clk); #1;
    desc_val = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    vectors++; if (byteIn_ready !== 1'b1) begin miscompares++; $display("FAIL mid_in_payload: got %b want 1", byteIn_ready); end
    reset_b = 1'b0;
    #1;
    vectors++; if (dataOut_val !== 1'b0 || dataOut !== 32'h0 || dataOut_last !== 1'b0) begin
      miscompares++; $display("FAIL mid_reset_out: got %b/%h/%b want 0/0/0", dataOut_val, dataOut, dataOut_last);
    end
    vectors++; if (byteIn_ready !== 1'b0 || desc_ready !== 1'b0) begin
      miscompares++; $display("FAIL mid_reset_ready: got %b/%b want 0/0", byteIn_ready, desc_ready);
    end
    byteIn_val = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_b = 1'b1;
    expPkt = 0;
    drive_packet(16'd12, 16'd20, 8'h01, -1);
    expPkt++;
    vectors++;
    if (capW.size() != 5 || capW[1] !== 32'h0100_0000 || capW[4] !== 32'h090A_0B0C || capL[4] !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_after_reset: got %0d words seq %h want 5 words seq 01000000",
               capW.size(), (capW.size() > 1) ? capW[1] : 32'hx);
    end
`ifdef FRAMER_PKT_CNT_EN
    vectors++; if (pktCount !== 32'(expPkt)) begin miscompares++; $display("FAIL mid_pkt_count: got %0d want %0d", pktCount, expPkt); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_short();
    test_stall();
    test_reject();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
